read_burst_addr_gen: RTL
========================

Name: read_burst_addr_gen

Overview:
- Sits directly downstream of ReadSlave's AR-channel capture and feeds its R-channel beat path.
- Takes one accepted read-burst command (ID, address, length, size, burst type) and walks the per-beat device addresses for FIXED, INCR and WRAP bursts.
- Strobes the device read, registers returned data into a one-entry output beat register, and tags each beat with ID, RLAST and RRESP.
- Enforces valid/ready backpressure toward the R channel.

Parameters:
- ADDR_WIDTH, 32, address bus width in bits.
- DATA_WIDTH, 32, device and R data width in bits.
- ID_WIDTH, 2, transaction ID width in bits.

Ports:
- ACLK  in  1  system clock, rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  block can accept a command.
- cmd_id  in  ID_WIDTH  ARID of the burst.
- cmd_addr  in  ADDR_WIDTH  ARADDR, start address.
- cmd_len  in  4  ARLEN; beats = cmd_len+1.
- cmd_size  in  2  ARSIZE; bytes per beat = 1<<cmd_size.
- cmd_burst  in  2  ARBURST: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- address_out  out  ADDR_WIDTH  device read address.
- devread  out  1  device read strobe.
- data_in  in  DATA_WIDTH  device read data, combinational from address_out.
- beat_valid  out  1  output beat valid (RVALID).
- beat_ready  in  1  consumer accepts beat (RREADY).
- beat_id  out  ID_WIDTH  RID.
- beat_data  out  DATA_WIDTH  RDATA.
- beat_resp  out  2  RRESP: 00 OKAY, 10 SLVERR.
- beat_last  out  1  RLAST.
- busy  out  1  burst in progress or beat pending.

Behaviour:
- Reset (async, ARESETn=0):
  - state IDLE; beat_valid, beat_last, devread, busy = 0.
  - beat_data, beat_id, beat_resp, address_out = 0.
  - An in-flight burst is discarded with no further beats. Release is clean on the next ACLK edge.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command, set cur_addr=cmd_addr, beat_cnt=0, and precompute error and wrap bounds. Next state ACTIVE.
  - ACTIVE: cmd_ready=0.
    - cap = !beat_valid || beat_ready.
    - devread = cap (combinational). address_out = cur_addr in all states.
    - On cap, the edge loads beat_data=data_in, beat_id, beat_resp and beat_last=(beat_cnt==len), and sets beat_valid=1.
    - On the last capture the state returns to IDLE; otherwise beat_cnt++ and cur_addr advances.
- Output register:
  - beat_valid clears on beat_ready when no new capture happens in the same cycle.
  - beat_* fields hold stable while beat_valid && !beat_ready.
- Latency: first beat_valid one cycle after the command handshake. Sustained rate is 1 beat/cycle when beat_ready=1.
- Back-to-back commands: a command may be accepted in IDLE while the last beat is still pending. Its first capture waits for cap.
- busy = (state==ACTIVE) || beat_valid.
- Address arithmetic (bytes=1<<size, all mod 2^ADDR_WIDTH, no 4KB check):
  - FIXED: cur_addr is constant.
  - INCR: next = (cur_addr & ~(bytes-1)) + bytes. An unaligned first beat aligns on the second.
  - WRAP: wrap_bytes=bytes*(len+1); lower = cmd_addr & ~(wrap_bytes-1); next = cur_addr+bytes. If next == lower+wrap_bytes, then next = lower.
  - WRAP with len not in {1,3,7,15}: treated as INCR.
  - Reserved burst 3: addressed as INCR, every beat resp=10.
  - size 3 (8 B > 32-bit bus): every beat resp=10, addressing as decoded.
- Otherwise every beat resp=00.

Optional Feature:
- Macro: READ_BURST_ERR_CHECK_EN.
- When defined: a WRAP burst whose len is not in {1,3,7,15}, or whose cmd_addr is not aligned to bytes, is flagged at acceptance.
  - It still produces len+1 beats with beat_last on the final beat.
  - devread is held 0 for the whole burst.
  - beat_data=0 and beat_resp=10 on every beat.
- When undefined: no check; such bursts follow the WRAP/INCR rules above with OKAY responses.

Test Plan:
1. INCR addr 0x00001000 len 3 size 2, beat_ready=1 -> address_out 0x1000,0x1004,0x1008,0x100C on consecutive devread cycles; beat_last only on beat 4; resp 00.
2. WRAP addr 0x00002228 len 3 size 2 -> addresses 0x2228,0x222C,0x2220,0x2224; beat_last on 0x2224.
3. FIXED addr 0x00001111 len 2 size 1 -> three beats, all at 0x1111, ID preserved; INCR unaligned 0x1111 len 1 size 1 -> 0x1111, 0x1112.
4. INCR len 3 with beat_ready=0 for 3 cycles after beat 1 -> beat_data/beat_last/beat_id stable, devread=0, address_out frozen; resumes at next address with no beat lost or duplicated.
5. ARESETn pulsed low during beat 2 of len 3 -> outputs 0 asynchronously; after release cmd_ready=1 and no stale beats; a new burst runs normally.
6. WRAP len 2 addr 0x2220 size 2 with READ_BURST_ERR_CHECK_EN -> 3 beats resp 10, data 0, devread never high; without the macro -> INCR 0x2220,0x2224,0x2228, resp 00.

Source files
------------

// File: rtl/read_burst_addr_gen_if.sv
// Command, device-read and R-beat signals of read_burst_addr_gen.
// slave = the address generator, master = its surroundings.
interface read_burst_addr_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [3:0]            cmd_len;
    logic [1:0]            cmd_size;
    logic [1:0]            cmd_burst;
    logic [ADDR_WIDTH-1:0] address_out;
    logic                  devread;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  beat_valid;
    logic                  beat_ready;
    logic [ID_WIDTH-1:0]   beat_id;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [1:0]            beat_resp;
    logic                  beat_last;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  data_in, beat_ready,
        output cmd_ready, address_out, devread,
        output beat_valid, beat_id, beat_data, beat_resp, beat_last, busy
    );

    modport master (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output data_in, beat_ready,
        input  cmd_ready, address_out, devread,
        input  beat_valid, beat_id, beat_data, beat_resp, beat_last, busy
    );
endinterface

// File: rtl/read_burst_addr_gen.sv
// Read-burst beat address walker with one-entry R beat register.
// READ_BURST_ERR_CHECK_EN: reject malformed WRAP bursts with SLVERR beats.
module read_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input logic ACLK,
    input logic ARESETn,
    read_burst_addr_gen_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    state_t              state;
    addr_t               cur_addr;
    addr_t               bytes_q;
    addr_t               lower_q;
    addr_t               upper_q;
    logic [3:0]          len_q;
    logic [3:0]          beat_cnt;
    logic [ID_WIDTH-1:0] id_q;
    logic                fixed_q;
    logic                wrap_q;
    logic                err_q;
    logic                mute_q;

    logic                  valid_q;
    logic                  last_q;
    logic [1:0]            resp_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] data_q;

    addr_t cmd_bytes;
    addr_t cmd_span;
    logic  wrap_len_ok;
    logic  cmd_mute;
    logic  cap;
    addr_t nxt_addr;

    always_comb begin
        cmd_bytes   = addr_t'(1) << bus.cmd_size;
        cmd_span    = cmd_bytes * (addr_t'(bus.cmd_len) + addr_t'(1));
        wrap_len_ok = (bus.cmd_len == 4'd1) || (bus.cmd_len == 4'd3) ||
                      (bus.cmd_len == 4'd7) || (bus.cmd_len == 4'd15);
`ifdef READ_BURST_ERR_CHECK_EN
        cmd_mute = (bus.cmd_burst == 2'd2) &&
                   (!wrap_len_ok ||
                    ((bus.cmd_addr & (cmd_bytes - addr_t'(1))) != '0));
`else
        cmd_mute = 1'b0;
`endif
    end

    assign cap = (state == ACTIVE) && (!valid_q || bus.beat_ready);

    // WRAP with an illegal length falls through to INCR via wrap_q=0
    always_comb begin
        nxt_addr = cur_addr;
        unique case (1'b1)
            fixed_q: nxt_addr = cur_addr;
            wrap_q: begin
                nxt_addr = cur_addr + bytes_q;
                if (nxt_addr == upper_q)
                    nxt_addr = lower_q;
            end
            default:
                nxt_addr = (cur_addr & ~(bytes_q - addr_t'(1))) + bytes_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            cur_addr <= '0;
            bytes_q  <= '0;
            lower_q  <= '0;
            upper_q  <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            id_q     <= '0;
            fixed_q  <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            mute_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            resp_q   <= 2'b00;
            rid_q    <= '0;
            data_q   <= '0;
        end else begin
            if (cap) begin
                data_q  <= mute_q ? '0 : bus.data_in;
                rid_q   <= id_q;
                resp_q  <= err_q ? 2'b10 : 2'b00;
                last_q  <= (beat_cnt == len_q);
                valid_q <= 1'b1;
            end else if (bus.beat_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state    <= ACTIVE;
                        cur_addr <= bus.cmd_addr;
                        bytes_q  <= cmd_bytes;
                        lower_q  <= bus.cmd_addr & ~(cmd_span - addr_t'(1));
                        upper_q  <= (bus.cmd_addr & ~(cmd_span - addr_t'(1)))
                                    + cmd_span;
                        len_q    <= bus.cmd_len;
                        beat_cnt <= '0;
                        id_q     <= bus.cmd_id;
                        fixed_q  <= (bus.cmd_burst == 2'd0);
                        wrap_q   <= (bus.cmd_burst == 2'd2) && wrap_len_ok;
                        err_q    <= (bus.cmd_burst == 2'd3) ||
                                    (bus.cmd_size == 2'd3) || cmd_mute;
                        mute_q   <= cmd_mute;
                    end
                end
                ACTIVE: begin
                    if (cap) begin
                        if (beat_cnt == len_q) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                            cur_addr <= nxt_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.devread     = cap && !mute_q;
    assign bus.address_out = cur_addr;
    assign bus.beat_valid  = valid_q;
    assign bus.beat_id     = rid_q;
    assign bus.beat_data   = data_q;
    assign bus.beat_resp   = resp_q;
    assign bus.beat_last   = last_q;
    assign bus.busy        = (state == ACTIVE) || valid_q;
endmodule
